// File: rtl/safety_island_periph_demux_pkg.sv
// safety_island_periph_demux_pkg: safety island peripheral address map types
// and the constants shared by the peripheral demultiplexer.
package safety_island_periph_demux_pkg;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned NumPorts = 8;
  localparam int unsigned NumRules = 8;
  localparam int unsigned AxiMaxOutTrans = 2;
  localparam int unsigned MaxTrans = AxiMaxOutTrans;
  localparam logic [31:0] ErrRdata = 32'hBADCAB1E;
  typedef enum logic [2:0] {
    PeriphSocCtrl,
    PeriphCoreLocal,
    PeriphBootRom,
    PeriphDebug,
    PeriphEccMgr,
    PeriphTimer,
    PeriphCluster,
    PeriphMailbox
  } periph_outputs_e;
  typedef logic [$clog2(NumPorts+1)-1:0] periph_sel_t;
  typedef struct packed {
    logic [31:0]          idx;
    logic [AddrWidth-1:0] start_addr;
    logic [AddrWidth-1:0] end_addr;
  } addr_map_rule_t;
endpackage

// File: rtl/safety_island_err_responder.sv
// safety_island_err_responder: answers every handshake to an unmapped address
// exactly one cycle later with an error and a fixed read pattern.
module safety_island_err_responder
  import safety_island_periph_demux_pkg::*;
#(
  parameter int unsigned DataWidth = safety_island_periph_demux_pkg::DataWidth,
  parameter int unsigned MaxTrans = safety_island_periph_demux_pkg::MaxTrans,
  parameter logic [DataWidth-1:0] ErrRdata = safety_island_periph_demux_pkg::ErrRdata
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hs,
  output logic                 rvalid,
  output logic [DataWidth-1:0] rdata,
  output logic                 err
);
  logic [$clog2(MaxTrans+1)-1:0] cnt_q;
  logic pend_q;
  assign rvalid = pend_q && cnt_q != '0;
  assign rdata = rvalid ? ErrRdata : '0;
  assign err = rvalid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q <= (hs && !rvalid) ? cnt_q + 1'b1 : (!hs && rvalid) ? cnt_q - 1'b1 : cnt_q;
      pend_q <= hs;
    end
  end
endmodule

// File: rtl/safety_island_periph_demux.sv
// safety_island_periph_demux: routes one manager request to a peripheral port by
// address rule, keeping responses in order by stalling on a target change.
module safety_island_periph_demux
  import safety_island_periph_demux_pkg::*;
#(
  parameter int unsigned NumPorts = safety_island_periph_demux_pkg::NumPorts,
  parameter int unsigned NumRules = safety_island_periph_demux_pkg::NumRules,
  parameter int unsigned AddrWidth = safety_island_periph_demux_pkg::AddrWidth,
  parameter int unsigned DataWidth = safety_island_periph_demux_pkg::DataWidth,
  parameter int unsigned MaxTrans = safety_island_periph_demux_pkg::MaxTrans,
  parameter logic [DataWidth-1:0] ErrRdata = safety_island_periph_demux_pkg::ErrRdata,
  parameter type rule_t = addr_map_rule_t
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  rule_t [NumRules-1:0]               addr_map_i,
  input  logic                               mgr_req_i,
  output logic                               mgr_gnt_o,
  input  logic [AddrWidth-1:0]               mgr_addr_i,
  input  logic                               mgr_we_i,
  input  logic [DataWidth/8-1:0]             mgr_be_i,
  input  logic [DataWidth-1:0]               mgr_wdata_i,
  output logic                               mgr_rvalid_o,
  output logic [DataWidth-1:0]               mgr_rdata_o,
  output logic                               mgr_err_o,
  output logic [NumPorts-1:0]                sub_req_o,
  input  logic [NumPorts-1:0]                sub_gnt_i,
  output logic [AddrWidth-1:0]               sub_addr_o,
  output logic                               sub_we_o,
  output logic [DataWidth/8-1:0]             sub_be_o,
  output logic [DataWidth-1:0]               sub_wdata_o,
  input  logic [NumPorts-1:0]                sub_rvalid_i,
  input  logic [NumPorts-1:0][DataWidth-1:0] sub_rdata_i,
  input  logic [NumPorts-1:0]                sub_err_i,
  output logic                               spurious_rsp_o
);
  localparam int unsigned SelWidth = $clog2(NumPorts + 1);
  localparam int unsigned CntWidth = $clog2(MaxTrans + 1);
  typedef logic [SelWidth-1:0] sel_t;
  localparam sel_t ErrSel = sel_t'(NumPorts);

  sel_t dec, tgt_q;
  logic [CntWidth-1:0] cnt_q;
  logic stall, hs, pop;
  logic err_rvalid, err_err;
  logic [DataWidth-1:0] err_rdata;
  logic [NumPorts:0] gnt_ext, rvalid_ext, err_ext;
  logic [NumPorts:0][DataWidth-1:0] rdata_ext;
  logic [NumPorts-1:0] live;

  // Later rules overwrite earlier ones, so the highest matching index wins.
  always_comb begin
    dec = ErrSel;
    for (int i = 0; i < NumRules; i++)
      if (mgr_addr_i >= addr_map_i[i].start_addr && mgr_addr_i < addr_map_i[i].end_addr)
        dec = addr_map_i[i].idx < NumPorts ? sel_t'(addr_map_i[i].idx) : ErrSel;
  end

  assign stall = (cnt_q == CntWidth'(MaxTrans)) || (cnt_q != '0 && dec != tgt_q);
  assign gnt_ext = {1'b1, sub_gnt_i};
  assign mgr_gnt_o = !stall && gnt_ext[dec];
  assign sub_req_o = (mgr_req_i && !stall && dec != ErrSel) ? NumPorts'(1) << dec : '0;
  assign sub_addr_o = mgr_addr_i;
  assign sub_we_o = mgr_we_i;
  assign sub_be_o = mgr_be_i;
  assign sub_wdata_o = mgr_wdata_i;
  assign hs = mgr_req_i && mgr_gnt_o;

  safety_island_err_responder #(
    .DataWidth(DataWidth),
    .MaxTrans (MaxTrans),
    .ErrRdata (ErrRdata)
  ) u_err (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .hs    (hs && dec == ErrSel),
    .rvalid(err_rvalid),
    .rdata (err_rdata),
    .err   (err_err)
  );

  assign rvalid_ext = {err_rvalid, sub_rvalid_i};
  assign err_ext = {err_err, sub_err_i};
  assign rdata_ext = {err_rdata, sub_rdata_i};
  assign pop = cnt_q != '0 && rvalid_ext[tgt_q];
  assign mgr_rvalid_o = pop;
  assign mgr_rdata_o = pop ? rdata_ext[tgt_q] : '0;
  assign mgr_err_o = pop && err_ext[tgt_q];
  // Only the port holding outstanding work may answer; the shift drops out for the error target.
  assign live = cnt_q != '0 ? NumPorts'(1) << tgt_q : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      tgt_q <= ErrSel;
      spurious_rsp_o <= 1'b0;
    end else begin
      cnt_q <= (hs && !pop) ? cnt_q + 1'b1 : (!hs && pop) ? cnt_q - 1'b1 : cnt_q;
      if (hs)
        tgt_q <= dec;
      if (|(sub_rvalid_i & ~live))
        spurious_rsp_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_safety_island_periph_demux.sv
// tb_safety_island_periph_demux: directed and random traffic checked against a
// queue of outstanding transactions that models ordering and stalls.
module tb_safety_island_periph_demux;
  import safety_island_periph_demux_pkg::*;
  localparam int Err = NumPorts;

  logic clk = 1'b0;
  logic rst_ni;
  addr_map_rule_t [NumRules-1:0] map;
  logic mgr_req, mgr_gnt, mgr_we, mgr_rvalid, mgr_err, spur, sub_we;
  logic [31:0] mgr_addr, mgr_wdata, mgr_rdata, sub_addr, sub_wdata;
  logic [3:0] mgr_be, sub_be;
  logic [NumPorts-1:0] sub_req, sub_gnt, sub_rvalid, sub_err;
  logic [NumPorts-1:0][31:0] sub_rdata;

  always #5 clk = ~clk;

  safety_island_periph_demux dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .addr_map_i    (map),
    .mgr_req_i     (mgr_req),
    .mgr_gnt_o     (mgr_gnt),
    .mgr_addr_i    (mgr_addr),
    .mgr_we_i      (mgr_we),
    .mgr_be_i      (mgr_be),
    .mgr_wdata_i   (mgr_wdata),
    .mgr_rvalid_o  (mgr_rvalid),
    .mgr_rdata_o   (mgr_rdata),
    .mgr_err_o     (mgr_err),
    .sub_req_o     (sub_req),
    .sub_gnt_i     (sub_gnt),
    .sub_addr_o    (sub_addr),
    .sub_we_o      (sub_we),
    .sub_be_o      (sub_be),
    .sub_wdata_o   (sub_wdata),
    .sub_rvalid_i  (sub_rvalid),
    .sub_rdata_i   (sub_rdata),
    .sub_err_i     (sub_err),
    .spurious_rsp_o(spur)
  );

  typedef struct {
    int tgt;
    logic [31:0] data;
    bit err;
    int born;
  } txn_t;
  txn_t q[$];
  int cyc, n_checks, n_fail;
  bit spur_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int r = NumRules - 1; r >= 0; r--)
      if (a >= map[r].start_addr && a < map[r].end_addr) return int'(map[r].idx);
    return Err;
  endfunction

  // One bus cycle: drive, check combinational outputs before the edge, advance the model.
  task automatic step(input bit req, input logic [31:0] addr, input logic [NumPorts-1:0] gnt, input bit rsp);
    int d;
    bit stall, g, resp;
    logic [NumPorts-1:0] exp_req;
    txn_t t;
    @(negedge clk);
    mgr_req = req;
    mgr_addr = addr;
    mgr_we = 1'($urandom);
    mgr_be = 4'($urandom);
    mgr_wdata = $urandom;
    sub_gnt = gnt;
    sub_rvalid = '0;
    sub_err = NumPorts'($urandom);
    for (int p = 0; p < NumPorts; p++) sub_rdata[p] = $urandom;
    resp = 0;
    if (q.size() != 0) begin
      if (q[0].tgt == Err) resp = (cyc == q[0].born + 1);
      else if (rsp && cyc > q[0].born) begin
        resp = 1;
        sub_rvalid[q[0].tgt] = 1'b1;
        sub_rdata[q[0].tgt] = q[0].data;
        sub_err[q[0].tgt] = q[0].err;
      end
    end
    #1;
    d = decode(addr);
    stall = q.size() == MaxTrans || (q.size() != 0 && q[$].tgt != d);
    g = !stall && ((d == Err) ? 1'b1 : gnt[d]);
    exp_req = '0;
    if (req && !stall && d != Err) exp_req[d] = 1'b1;
    check("gnt", mgr_gnt, g);
    check("sub_req", sub_req, exp_req);
    check("sub_addr", sub_addr, addr);
    check("sub_wdata", sub_wdata, mgr_wdata);
    check("rvalid", mgr_rvalid, resp);
    check("rdata", mgr_rdata, !resp ? 32'h0 : (q[0].tgt == Err) ? 32'hBADCAB1E : q[0].data);
    if (resp) check("err", mgr_err, q[0].tgt == Err || q[0].err);
    check("spurious", spur, spur_exp);
    if (resp) void'(q.pop_front());
    if (req && g) begin
      t.tgt = d;
      t.data = $urandom;
      t.err = 1'($urandom_range(0, 1));
      t.born = cyc;
      q.push_back(t);
    end
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) step(0, 32'h0, '1, 1);
  endtask

  logic [31:0] pool [14] = '{32'h1004, 32'h5000, 32'h8000, 32'h8004, 32'h3000, 32'h0010, 32'hD000,
                             32'hC004, 32'h2008, 32'hA000, 32'h0FFF, 32'h1000, 32'h9000, 32'hD100};

  initial begin
    map[0] = '{idx: 32'(PeriphSocCtrl),   start_addr: 32'h0000, end_addr: 32'h1000};
    map[1] = '{idx: 32'(PeriphBootRom),   start_addr: 32'h1000, end_addr: 32'h2000};
    map[2] = '{idx: 32'(PeriphDebug),     start_addr: 32'h3000, end_addr: 32'h4000};
    map[3] = '{idx: 32'(PeriphEccMgr),    start_addr: 32'hC000, end_addr: 32'hE000};
    map[4] = '{idx: 32'(PeriphTimer),     start_addr: 32'h8000, end_addr: 32'h9000};
    map[5] = '{idx: 32'(PeriphCluster),   start_addr: 32'hD000, end_addr: 32'hD100};
    map[6] = '{idx: 32'(PeriphCoreLocal), start_addr: 32'h2000, end_addr: 32'h3000};
    map[7] = '{idx: 32'(PeriphMailbox),   start_addr: 32'hA000, end_addr: 32'hB000};
    rst_ni = 1'b0;
    mgr_req = 0; mgr_addr = 0; mgr_we = 0; mgr_be = 0; mgr_wdata = 0;
    sub_gnt = '0; sub_rvalid = '0; sub_err = '0; sub_rdata = '0;
    repeat (2) @(negedge clk);
    check("reset_rvalid", mgr_rvalid, 0);
    check("reset_rdata", mgr_rdata, 0);
    check("reset_spurious", spur, 0);
    rst_ni = 1'b1;

    step(1, 32'h1004, '1, 0);
    check("boot_gnt", mgr_gnt, 1);
    check("boot_req", sub_req, 8'h04);
    step(0, 32'h0, '1, 1);
    check("boot_rvalid", mgr_rvalid, 1);
    step(1, 32'h5000, '1, 0);
    check("unmapped_gnt", mgr_gnt, 1);
    check("unmapped_req", sub_req, 0);
    step(0, 32'h0, '1, 0);
    check("unmapped_rvalid", mgr_rvalid, 1);
    check("unmapped_err", mgr_err, 1);
    check("unmapped_rdata", mgr_rdata, 32'hBADCAB1E);

    step(1, 32'h8000, '1, 0);
    step(1, 32'h8004, '1, 0);
    step(1, 32'h8008, '1, 0);
    check("timer_full_stall", mgr_gnt, 0);
    step(1, 32'h8008, '1, 1);
    check("timer_pop_still_stalled", mgr_gnt, 0);
    check("timer_first_rsp", mgr_rvalid, 1);
    step(1, 32'h8008, '1, 0);
    check("timer_third_gnt", mgr_gnt, 1);
    drain();

    step(1, 32'h0010, '1, 0);
    step(1, 32'h3000, '1, 0);
    check("debug_stall", mgr_gnt, 0);
    step(1, 32'h3000, '1, 1);
    check("debug_stall_on_pop", mgr_gnt, 0);
    step(1, 32'h3000, '1, 0);
    check("debug_gnt", mgr_gnt, 1);
    check("debug_req", sub_req, 8'h08);
    drain();

    step(1, 32'hD000, '1, 0);
    check("overlap_req", sub_req, 8'h40);
    step(1, 32'h0FFF, '1, 1);
    step(1, 32'h1000, '1, 1);
    drain();

    for (int i = 0; i < 800; i++)
      step(1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0) ? $urandom : pool[$urandom_range(0, 13)],
           ($urandom_range(0, 1) == 1) ? '1 : NumPorts'($urandom),
           1'($urandom_range(0, 2) != 0));
    drain();

    step(1, 32'h8000, '1, 0);
    step(1, 32'h8004, '1, 0);
    @(negedge clk);
    rst_ni = 1'b0;
    mgr_req = 0;
    sub_rvalid = '0;
    q.delete();
    #1;
    check("midop_reset_rvalid", mgr_rvalid, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    sub_rvalid[PeriphTimer] = 1'b1;
    sub_rdata[PeriphTimer] = 32'h1234;
    #1;
    check("late_rsp_rvalid", mgr_rvalid, 0);
    check("late_rsp_rdata", mgr_rdata, 0);
    @(negedge clk);
    sub_rvalid = '0;
    spur_exp = 1;
    check("late_rsp_spurious", spur, 1);
    step(1, 32'h3000, '1, 0);
    check("post_reset_gnt", mgr_gnt, 1);
    drain();
    @(negedge clk);
    rst_ni = 1'b0;
    spur_exp = 0;
    #1;
    check("spurious_cleared", spur, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
